x25519_mult_sequencer: RTL and testbench
========================================

# x25519_mult_sequencer

Drives an X25519 multiplier pass unit through a complete multiply. On a start request it latches the 264-bit operands, issues `NUM_PASSES` passes with index `i = 0 … NUM_PASSES-1`, waits for each pass result and sums the results into a 264-bit accumulator. It sits on the initiator side of the pass unit's `en` / `i` / `out_valid` / `out` interface, between the curve-arithmetic scheduler and the pass datapath.

## Interface

Parameters:
- `NUM_PASSES`, default 32: passes per multiply; must be ≤ 32 because `pass_i` is 5 bits.
- `TIMEOUT_CYCLES`, default 64: watchdog limit in cycles; used only when the timeout feature is compiled in.

Ports (all outputs are registered):
- `clk` in 1: single clock; all logic is on its rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `start` in 1: request a multiply; sampled only in IDLE.
- `a` in 264: operand A; latched on an accepted start.
- `b` in 264: operand B; latched on an accepted start.
- `busy` out 1: high from the accepted start until `done`, inclusive.
- `done` out 1: one-cycle pulse; `result` is valid from this cycle.
- `result` out 264: accumulator value; held until the next accepted start.
- `error` out 1: one-cycle pulse on watchdog abort. Tied to 0 when the timeout feature is compiled out.
- `pass_en` out 1: one-cycle pulse that launches a pass.
- `pass_a` out 264: latched A, stable while busy.
- `pass_b` out 264: latched B, stable while busy.
- `pass_i` out 5: current pass index.
- `pass_valid` in 1: pass result strobe from the pass unit.
- `pass_out` in 264: pass result.

## Operation

The block is a four-state FSM: IDLE, ISSUE, WAIT, DONE.

- **Reset values:** state = IDLE; `busy`, `done`, `error`, `pass_en` = 0; `pass_i` = 0; `result`, `pass_a`, `pass_b` = 0; accumulator = 0; watchdog counter = 0.
- **IDLE:**
  - If `start` = 1: latch `a`/`b` into `pass_a`/`pass_b`, clear the accumulator, set `pass_i` = 0, assert `busy`, go to ISSUE.
  - Otherwise stay in IDLE.
- **ISSUE:** `pass_en` = 1 for exactly this cycle, then go to WAIT.
- **WAIT:**
  - On `pass_valid` = 1: accumulator ← (accumulator + `pass_out`) mod 2^264; the carry out of bit 263 is discarded.
  - If `pass_i` == `NUM_PASSES-1`, go to DONE.
  - Otherwise increment `pass_i` and go to ISSUE.
- **DONE:**
  - `result` ← accumulator, asserted in the same cycle as the `done` pulse.
  - `busy` = 1 during this cycle, then 0.
  - Next state is IDLE.
- `result` always equals the accumulator as of the last completed multiply or abort; it is not updated mid-operation.
- **Ignored inputs:**
  - `start` is ignored in ISSUE, WAIT and DONE. It is not queued.
  - `pass_valid` is ignored outside WAIT, including in the ISSUE cycle.
- **Operand stability:** `a`/`b` changes while busy have no effect.
- **Reset mid-operation:** asynchronously returns every register to its reset value. An in-flight `pass_out` arriving after reset is ignored (the FSM is in IDLE).

## Timing

- Edge E0 samples `start` = 1 in IDLE. The first `pass_en` is high in the cycle after E0.
- Pass unit latency L ≥ 1: `pass_valid` arrives L cycles after `pass_en`. Back-to-back passes are therefore L+1 cycles apart.
- `done` is high exactly `NUM_PASSES*(L+1) + 1` cycles after E0.
  - Example: L = 3, `NUM_PASSES` = 32 gives 129 cycles.
- The earliest new start is accepted on the edge ending the cycle after `done` (IDLE).
- Zero-latency pass units (L = 0) are not supported.

## Configuration

- Macro: `X25519_SEQ_TIMEOUT_EN`.
- **When defined:**
  - A watchdog counter clears on each `pass_en` and increments every cycle in WAIT.
  - If it reaches `TIMEOUT_CYCLES` without `pass_valid`:
    - `error` pulses for one cycle;
    - `result` ← partial accumulator;
    - `busy` drops on the following cycle;
    - the FSM returns to IDLE;
    - `done` is not asserted.
  - If `pass_valid` arrives in the same cycle the counter reaches the limit, the pass result wins: it is accepted normally and no error is raised.
- **When undefined:** no counter is built, `error` = 0 constantly, and WAIT waits indefinitely.

## Test plan

- **Reset values:** assert `rst_n` = 0 mid-WAIT → all outputs return to their reset values immediately. After release, the first `start` runs a full, correct multiply.
- **Basic sum:** pass-unit stub with L = 3, `pass_out` = `pass_i`+1 → `result` = 0x210 (sum 1..32), `done` at 129 cycles after E0, `pass_i` sequence 0…31 with one `pass_en` per pass.
- **Carry discard:** stub returns all-ones (2^264−1) every pass → `result` = 2^264−32 (0xFF…FE0, all 264 bits set except bits 4:0 clear).
- **Ignored inputs:** `start` pulsed in WAIT, and `pass_valid` pulsed in ISSUE and in IDLE → no restart, no extra accumulation, `result` unchanged from the basic-sum case.
- **Operand latch:** change `a`/`b` mid-operation → `pass_a`/`pass_b` hold the start-time values throughout.
- **Watchdog** (with `X25519_SEQ_TIMEOUT_EN`): stub answers passes 0–4 with `pass_out` = 1, then goes silent → `error` pulses 64 cycles after pass 5's `pass_en`, `result` = 5, `done` never asserted. Without the macro, the same stimulus leaves `busy` = 1 indefinitely.

Source files
------------

// File: rtl/x25519_mult_sequencer_if.sv
// Pass-unit bus between the X25519 multiply sequencer (master) and the
// multiplier pass datapath (slave): launch strobe, operands, pass index,
// and the returning result strobe and value.
interface x25519_mult_sequencer_if;
  logic         pass_en;
  logic [263:0] pass_a;
  logic [263:0] pass_b;
  logic [4:0]   pass_i;
  logic         pass_valid;
  logic [263:0] pass_out;

  modport master (
    output pass_en, pass_a, pass_b, pass_i,
    input  pass_valid, pass_out
  );

  modport slave (
    input  pass_en, pass_a, pass_b, pass_i,
    output pass_valid, pass_out
  );
endinterface

// File: rtl/x25519_mult_sequencer.sv
// X25519 multiply sequencer: latches the operands on start, launches
// NUM_PASSES passes on the pass unit, and sums the pass results into a
// 264-bit accumulator (carry out of bit 263 dropped).
// Optional watchdog: define X25519_SEQ_TIMEOUT_EN to abort a multiply when a
// pass result does not return within TIMEOUT_CYCLES cycles of its launch.
module x25519_mult_sequencer #(
  parameter int NUM_PASSES     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [263:0]            a,
  input  logic [263:0]            b,
  output logic                    busy,
  output logic                    done,
  output logic [263:0]            result,
  output logic                    error,
  x25519_mult_sequencer_if.master pass_bus
);

  localparam int         DATA_W    = 264;
  localparam logic [4:0] LAST_PASS = 5'(NUM_PASSES - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_e;

  state_e              state_q, state_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                pass_en_q, pass_en_d;
  logic [4:0]          pass_i_q, pass_i_d;
  logic [DATA_W-1:0]   pass_a_q, pass_a_d;
  logic [DATA_W-1:0]   pass_b_q, pass_b_d;
  logic [DATA_W-1:0]   acc_q, acc_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic [DATA_W-1:0]   sum;
  logic                timeout;

  // Modulo-2^264 add: the carry is simply not kept.
  assign sum = acc_q + pass_bus.pass_out;

  // Next-state and next-output logic for the IDLE/ISSUE/WAIT/DONE sequence.
  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pass_en_d = 1'b0;
    pass_i_d  = pass_i_q;
    pass_a_d  = pass_a_q;
    pass_b_d  = pass_b_q;
    acc_d     = acc_q;
    result_d  = result_q;
    unique case (state_q)
      IDLE: begin
        // busy may still be high here for the one cycle after an abort.
        busy_d = 1'b0;
        if (start) begin
          pass_a_d  = a;
          pass_b_d  = b;
          acc_d     = '0;
          pass_i_d  = '0;
          busy_d    = 1'b1;
          pass_en_d = 1'b1;
          state_d   = ISSUE;
        end
      end
      ISSUE: begin
        state_d = WAIT;
      end
      WAIT: begin
        if (pass_bus.pass_valid) begin
          acc_d = sum;
          if (pass_i_q == LAST_PASS) begin
            result_d = sum;
            done_d   = 1'b1;
            state_d  = DONE;
          end else begin
            pass_i_d  = pass_i_q + 5'd1;
            pass_en_d = 1'b1;
            state_d   = ISSUE;
          end
        end else if (timeout) begin
          // Abort: publish the partial sum; busy is held one more cycle.
          result_d = acc_q;
          state_d  = IDLE;
        end
      end
      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs, all cleared by the asynchronous reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_en_q <= 1'b0;
      pass_i_q  <= '0;
      pass_a_q  <= '0;
      pass_b_q  <= '0;
      acc_q     <= '0;
      result_q  <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_en_q <= pass_en_d;
      pass_i_q  <= pass_i_d;
      pass_a_q  <= pass_a_d;
      pass_b_q  <= pass_b_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
    end
  end

`ifdef X25519_SEQ_TIMEOUT_EN
  localparam int              WD_W     = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);

  logic [WD_W-1:0] wdog_q;
  logic [WD_W-1:0] wdog_inc;
  logic            error_q;

  // The counter holds the number of cycles since the current pass_en, so the
  // abort lands exactly TIMEOUT_CYCLES cycles after the launch; a result in
  // the limit cycle is checked first in the FSM and therefore wins.
  assign wdog_inc = wdog_q + WD_W'(1);
  assign timeout  = (state_q == WAIT) && !pass_bus.pass_valid && (wdog_inc == WD_LIMIT);

  // Watchdog counter and the one-cycle error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wdog_q  <= '0;
      error_q <= 1'b0;
    end else begin
      error_q <= timeout;
      if (pass_en_d) begin
        wdog_q <= '0;
      end else if (state_q == ISSUE || state_q == WAIT) begin
        wdog_q <= wdog_inc;
      end
    end
  end

  assign error = error_q;
`else
  // Without the watchdog WAIT never gives up; the limit has no effect.
  assign timeout = 1'b0 & (TIMEOUT_CYCLES != 0);
  assign error   = 1'b0;
`endif

  assign busy             = busy_q;
  assign done             = done_q;
  assign result           = result_q;
  assign pass_bus.pass_en = pass_en_q;
  assign pass_bus.pass_a  = pass_a_q;
  assign pass_bus.pass_b  = pass_b_q;
  assign pass_bus.pass_i  = pass_i_q;

endmodule

// File: tb/tb_x25519_mult_sequencer.sv
// Testbench for x25519_mult_sequencer: a pass-unit stub with programmable
// latency and result pattern, and a reference sum/timing model.
module tb_x25519_mult_sequencer;

  localparam int N  = 32;
  localparam int TO = 64;

  logic         clk   = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [263:0] a     = '0;
  logic [263:0] b     = '0;
  logic         busy, done, error;
  logic [263:0] result;

  x25519_mult_sequencer_if bus ();

  x25519_mult_sequencer #(.NUM_PASSES(N), .TIMEOUT_CYCLES(TO)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .a        (a),
    .b        (b),
    .busy     (busy),
    .done     (done),
    .result   (result),
    .error    (error),
    .pass_bus (bus)
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Stub control (written only by the main initial block).
  int           stub_mode = 0;
  int           stub_lat  = 3;
  bit           inj_issue = 1'b0;
  bit           inj_idle  = 1'b0;
  logic [263:0] rnd_val [N];

  // Stub state (written only by the stub).
  int         stub_rem = 0;
  logic [4:0] stub_idx = '0;

  // Result pattern per mode: 0 -> i+1, 1 -> all ones, 2 -> random table,
  // 3 -> ones for the passes that are answered.
  function automatic logic [263:0] pass_value(int mode, int idx);
    case (mode)
      0:       return 264'(idx + 1);
      1:       return {264{1'b1}};
      2:       return rnd_val[idx];
      default: return 264'd1;
    endcase
  endfunction

  function automatic bit answers(int mode, int idx);
    return (mode == 3) ? (idx < 5) : 1'b1;
  endfunction

  // Reference: plain modular sum of every answered pass result.
  function automatic logic [263:0] model_sum(int mode);
    logic [263:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++)
      if (answers(mode, i)) acc = acc + pass_value(mode, i);
    return acc;
  endfunction

  function automatic logic [263:0] rand264();
    logic [263:0] v;
    v = '0;
    for (int w = 0; w < 9; w++) v = (v << 32) | 264'($urandom);
    return v;
  endfunction

  // Pass-unit stub: answers each pass_en stub_lat cycles later.
  always @(posedge clk) begin : stub
    logic       en_s;
    logic [4:0] i_s;
    en_s = bus.pass_en;
    i_s  = bus.pass_i;
    #1;
    bus.pass_valid = 1'b0;
    if (en_s) begin
      stub_rem = stub_lat;
      stub_idx = i_s;
    end
    if (stub_rem > 0) begin
      stub_rem = stub_rem - 1;
      if (stub_rem == 0 && answers(stub_mode, int'(stub_idx))) begin
        bus.pass_valid = 1'b1;
        bus.pass_out   = pass_value(stub_mode, int'(stub_idx));
      end
    end
    if ((inj_issue && bus.pass_en) || inj_idle) begin
      bus.pass_valid = 1'b1;
      bus.pass_out   = {33{8'hA5}};
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic chk(input string tag, input logic [263:0] obs, input logic [263:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_busy"},    264'(busy),        264'(0));
    chk({pfx, "_done"},    264'(done),        264'(0));
    chk({pfx, "_error"},   264'(error),       264'(0));
    chk({pfx, "_pass_en"}, 264'(bus.pass_en), 264'(0));
    chk({pfx, "_pass_i"},  264'(bus.pass_i),  264'(0));
    chk({pfx, "_result"},  result,            264'(0));
    chk({pfx, "_pass_a"},  bus.pass_a,        264'(0));
    chk({pfx, "_pass_b"},  bus.pass_b,        264'(0));
  endtask

  // Called at edge+1 in IDLE; returns at edge+1 of the cycle after E0.
  task automatic do_start(input logic [263:0] av, input logic [263:0] bv);
    a     = av;
    b     = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic run_mult(input int mode, input int lat, input bit disturb);
    logic [263:0] av, bv, expv;
    int           n, en_cnt, exp_n;
    bit           seen;
    stub_mode = mode;
    stub_lat  = lat;
    av        = rand264();
    bv        = rand264();
    expv      = model_sum(mode);
    exp_n     = N * (lat + 1) + 1;
    do_start(av, bv);
    n      = 1;
    en_cnt = 0;
    seen   = 1'b0;
    while (n <= exp_n + 40) begin
      if (bus.pass_en) begin
        chk("pass_i_seq", 264'(bus.pass_i), 264'(en_cnt));
        chk("pass_a_hold", bus.pass_a, av);
        chk("pass_b_hold", bus.pass_b, bv);
        en_cnt++;
      end
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (disturb) begin
        if (n == 3)  start = 1'b1;
        if (n == 4)  start = 1'b0;
        if (n == 6)  inj_issue = 1'b1;
        if (n == 10) inj_issue = 1'b0;
        if (n == 7) begin
          a = ~av;
          b = ~bv;
        end
      end
      @(posedge clk); #1;
      n++;
    end
    start     = 1'b0;
    inj_issue = 1'b0;
    chk("done_seen", 264'(seen), 264'(1));
    chk("done_cycle", 264'(n), 264'(exp_n));
    chk("result", result, expv);
    chk("busy_at_done", 264'(busy), 264'(1));
    chk("pass_en_count", 264'(en_cnt), 264'(N));
    chk("error_quiet", 264'(error), 264'(0));
    @(posedge clk); #1;
    chk("busy_after_done", 264'(busy), 264'(0));
    chk("done_one_cycle", 264'(done), 264'(0));
    chk("result_held", result, expv);
  endtask

  initial begin : main
    logic [263:0] prev;
    int           n, p;
    bit           seen_err, seen_done;

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    chk_reset_vals("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic sum, L = 3.
    run_mult(0, 3, 1'b0);
    chk("basic_sum_const", result, 264'h210);

    // Same run with start in WAIT, pass_valid in ISSUE and operand changes.
    run_mult(0, 3, 1'b1);
    chk("ignored_sum_const", result, 264'h210);

    // pass_valid while IDLE.
    #1;
    inj_idle = 1'b1;
    @(posedge clk); #2;
    inj_idle = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_valid_result", result, 264'h210);
    chk("idle_valid_busy", 264'(busy), 264'(0));
    chk("idle_valid_pass_en", 264'(bus.pass_en), 264'(0));

    // Carry discard, L = 1.
    run_mult(1, 1, 1'b0);
    chk("carry_const", result, ~264'd31);

    // Random results and latencies.
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < N; i++) rnd_val[i] = rand264();
      run_mult(2, int'($urandom_range(4, 1)), 1'b0);
    end

    // Reset in the middle of WAIT.
    stub_mode = 0;
    stub_lat  = 3;
    do_start(rand264(), rand264());
    repeat (18) @(posedge clk);
    #2;
    chk("pre_reset_busy", 264'(busy), 264'(1));
    rst_n = 1'b0;
    #1;
    chk_reset_vals("rst_mid");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("post_reset_idle", 264'(busy), 264'(0));
    run_mult(0, 3, 1'b0);

    // Watchdog stimulus: passes 0-4 answered, pass 5 never answered.
    prev      = result;
    stub_mode = 3;
    stub_lat  = 2;
    do_start(rand264(), rand264());
    n         = 1;
    p         = -1000;
    seen_err  = 1'b0;
    seen_done = 1'b0;
`ifdef X25519_SEQ_TIMEOUT_EN
    while (n <= 400) begin
      if (bus.pass_en && bus.pass_i == 5'd5) p = n;
      if (done) seen_done = 1'b1;
      if (error) begin
        seen_err = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    chk("wd_error_seen", 264'(seen_err), 264'(1));
    chk("wd_error_delay", 264'(n - p), 264'(TO));
    chk("wd_result", result, model_sum(3));
    chk("wd_busy_in_error", 264'(busy), 264'(1));
    chk("wd_no_done", 264'(seen_done), 264'(0));
    @(posedge clk); #1;
    chk("wd_busy_dropped", 264'(busy), 264'(0));
    chk("wd_error_pulse", 264'(error), 264'(0));
    chk("wd_done_low", 264'(done), 264'(0));
`else
    while (n <= 300) begin
      if (done) seen_done = 1'b1;
      if (error) seen_err = 1'b1;
      @(posedge clk); #1;
      n++;
    end
    chk("nowd_busy_stuck", 264'(busy), 264'(1));
    chk("nowd_no_error", 264'(seen_err), 264'(0));
    chk("nowd_no_done", 264'(seen_done), 264'(0));
    chk("nowd_result_held", result, prev);
    rst_n = 1'b0;
    #1;
    chk("nowd_reset_busy", 264'(busy), 264'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
`endif
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
